// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK control sequencer.
// Ports: clk, rst (async high); opcode and cu_* decode in; mem_ready, stall
// handshakes in; imem/dmem request, ir_load, pc_write, rf_write_en strobes,
// state, sticky illegal/timeout traps, retired pulse and instret_count out.
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             cu_reg_write,
    input  logic             cu_mem_read,
    input  logic             cu_mem_write,
    input  logic             mem_ready,
    input  logic             stall,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_load,
    output logic             pc_write,
    output logic             rf_write_en,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             timeout,
    output logic             retired,
    output logic [CNT_W-1:0] instret_count
);

    localparam int WCW = $clog2(MEM_TIMEOUT);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEM       = 3'd3,
        WRITEBACK = 3'd4,
        TRAP      = 3'd7
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WCW-1:0]   wait_cnt;
    logic             wait_clr;
    logic             wait_inc;
    logic             set_illegal;
    logic             set_timeout;
    logic             imem_c;
    logic             dmem_c;
    logic             we_c;
    logic             ir_c;
    logic             pcw_c;
    logic             rfw_c;
    logic             ret_c;
    logic             illegal_q;
    logic             timeout_q;
    logic [CNT_W-1:0] cnt_q;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011, 7'b0000011,
            7'b0100011, 7'b1100011, 7'b1101111,
            7'b1100111, 7'b0110111, 7'b0010111: is_legal = 1'b1;
            default:                            is_legal = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_q | set_illegal;
            timeout_q <= timeout_q | set_timeout;
            if (wait_clr)
                wait_cnt <= '0;
            else if (wait_inc)
                wait_cnt <= wait_cnt + WCW'(1);
            if (ret_c)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_clr    = 1'b0;
        wait_inc    = 1'b0;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        imem_c      = 1'b0;
        dmem_c      = 1'b0;
        we_c        = 1'b0;
        ir_c        = 1'b0;
        pcw_c       = 1'b0;
        rfw_c       = 1'b0;
        ret_c       = 1'b0;
        unique case (state_q)
            FETCH: begin
                imem_c = 1'b1;
                // A late acknowledge on the last allowed cycle still wins.
                if (mem_ready) begin
                    ir_c    = 1'b1;
                    state_d = DECODE;
                end else if (wait_cnt == WAIT_MAX) begin
                    set_timeout = 1'b1;
                    state_d     = TRAP;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            DECODE: begin
                if (is_legal(opcode)) begin
                    state_d = EXECUTE;
                end else begin
                    set_illegal = 1'b1;
                    state_d     = TRAP;
                end
            end
            EXECUTE: begin
                if (!stall) begin
                    if (cu_mem_read || cu_mem_write) begin
                        wait_clr = 1'b1;
                        state_d  = MEM;
                    end else begin
                        state_d = WRITEBACK;
                    end
                end
            end
            MEM: begin
                dmem_c = 1'b1;
                we_c   = cu_mem_write;
                if (mem_ready) begin
                    // Stores have nothing to write back and retire here.
                    if (cu_mem_write) begin
                        pcw_c    = 1'b1;
                        ret_c    = 1'b1;
                        wait_clr = 1'b1;
                        state_d  = FETCH;
                    end else begin
                        state_d = WRITEBACK;
                    end
                end else if (wait_cnt == WAIT_MAX) begin
                    set_timeout = 1'b1;
                    state_d     = TRAP;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            WRITEBACK: begin
                if (!stall) begin
                    rfw_c    = cu_reg_write;
                    pcw_c    = 1'b1;
                    ret_c    = 1'b1;
                    wait_clr = 1'b1;
                    state_d  = FETCH;
                end
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = TRAP;
            end
        endcase
    end

    // Strobes must be quiet while reset is held, even though state is FETCH.
    assign imem_req      = imem_c & ~rst;
    assign dmem_req      = dmem_c & ~rst;
    assign dmem_we       = we_c & ~rst;
    assign ir_load       = ir_c & ~rst;
    assign pc_write      = pcw_c & ~rst;
    assign rf_write_en   = rfw_c & ~rst;
    assign retired       = ret_c & ~rst;
    assign state         = state_q;
    assign illegal       = illegal_q;
    assign timeout       = timeout_q;
    assign instret_count = cnt_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench for multicycle_sequencer against a per-instruction
// cycle-trace model built from instruction class, wait and stall counts.
module tb_multicycle_sequencer;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [6:0]    opcode = 7'h33;
    logic          cu_reg_write = 1'b0;
    logic          cu_mem_read = 1'b0;
    logic          cu_mem_write = 1'b0;
    logic          mem_ready = 1'b0;
    logic          stall = 1'b0;
    logic          imem_req;
    logic          dmem_req;
    logic          dmem_we;
    logic          ir_load;
    logic          pc_write;
    logic          rf_write_en;
    logic [2:0]    state;
    logic          illegal;
    logic          timeout;
    logic          retired;
    logic [CW-1:0] instret_count;

    multicycle_sequencer #(.MEM_TIMEOUT(16), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode),
        .cu_reg_write(cu_reg_write), .cu_mem_read(cu_mem_read),
        .cu_mem_write(cu_mem_write), .mem_ready(mem_ready),
        .stall(stall), .imem_req(imem_req), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .ir_load(ir_load), .pc_write(pc_write),
        .rf_write_en(rf_write_en), .state(state), .illegal(illegal),
        .timeout(timeout), .retired(retired),
        .instret_count(instret_count)
    );

    always #5 clk = ~clk;

    // strobe vector: imem, dmem, we, ir, pcw, rfw, ret
    typedef struct {
        logic [2:0] st;
        logic [6:0] strb;
        logic       rdy;
        logic       stl;
        bit         rdy_x;
        bit         stl_x;
    } step_t;

    step_t         q[$];
    logic [CW-1:0] exp_cnt;
    int            n_checks = 0;
    int            n_errors = 0;
    logic [6:0]    cur_op;
    logic          cur_rw;
    logic          cur_mr;
    logic          cur_mw;
    logic [6:0]    strb_now;
    logic [6:0]    alu_ops[6];
    logic [6:0]    legal_ops[9];

    assign strb_now = {imem_req, dmem_req, dmem_we, ir_load,
                       pc_write, rf_write_en, retired};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [2:0] st, input logic [6:0] s,
                        input int rdy, input int stl);
        step_t e;
        e.st    = st;
        e.strb  = s;
        e.rdy_x = (rdy < 0);
        e.rdy   = (rdy > 0);
        e.stl_x = (stl < 0);
        e.stl   = (stl > 0);
        q.push_back(e);
    endtask

    // Starts and ends on a falling edge; inputs are applied there and
    // outputs sampled 1 time unit later.
    task automatic run_trace(input int limit);
        int n;
        step_t e;
        n = (limit < 0 || limit > q.size()) ? q.size() : limit;
        for (int i = 0; i < n; i++) begin
            e            = q[i];
            opcode       = cur_op;
            cu_reg_write = cur_rw;
            cu_mem_read  = cur_mr;
            cu_mem_write = cur_mw;
            mem_ready    = e.rdy_x ? 1'($urandom) : e.rdy;
            stall        = e.stl_x ? 1'($urandom) : e.stl;
            #1;
            check("state", 32'(state), 32'(e.st));
            check("strobes", 32'(strb_now), 32'(e.strb));
            check("instret", 32'(instret_count), 32'(exp_cnt));
            if (e.strb[0])
                exp_cnt++;
            @(negedge clk);
        end
        q.delete();
    endtask

    // cls: 0 alu/jump/upper, 1 branch, 2 load, 3 store
    task automatic model_instr(input int cls, input int fw, input int es,
                               input int mw, input int ws);
        bit st;
        st     = (cls == 3);
        cur_op = (cls == 0) ? alu_ops[$urandom_range(0, 5)] :
                 (cls == 1) ? 7'b1100011 :
                 (cls == 2) ? 7'b0000011 : 7'b0100011;
        cur_rw = (cls == 0 || cls == 2);
        cur_mr = (cls == 2);
        cur_mw = st;
        for (int i = 0; i < fw; i++)
            push(3'd0, 7'b1000000, 0, -1);
        push(3'd0, 7'b1001000, 1, -1);
        push(3'd1, 7'b0000000, -1, -1);
        for (int i = 0; i < es; i++)
            push(3'd2, 7'b0000000, -1, 1);
        push(3'd2, 7'b0000000, -1, 0);
        if (cls >= 2) begin
            for (int i = 0; i < mw; i++)
                push(3'd3, {2'b01, st, 4'b0000}, 0, -1);
            if (st)
                push(3'd3, 7'b0110101, 1, -1);
            else
                push(3'd3, 7'b0100000, 1, -1);
        end
        if (!st) begin
            for (int i = 0; i < ws; i++)
                push(3'd4, 7'b0000000, -1, 1);
            push(3'd4, {4'b0000, 1'b1, cur_rw, 1'b1}, -1, 0);
        end
    endtask

    // Enters at a falling edge, returns at the next falling edge
    // with rst just released and the sequencer still in FETCH.
    task automatic do_reset();
        rst       = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_strobes", 32'(strb_now), 32'd0);
        @(negedge clk);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_instret", 32'(instret_count), 32'd0);
        rst     = 1'b0;
        exp_cnt = '0;
    endtask

    function automatic bit model_legal(input logic [6:0] op);
        foreach (legal_ops[i])
            if (legal_ops[i] == op)
                return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        logic [6:0] bad;
        int cls;
        int fw;
        int mw;
        alu_ops   = '{7'h33, 7'h13, 7'h6F, 7'h67, 7'h37, 7'h17};
        legal_ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                      7'h6F, 7'h67, 7'h37, 7'h17};
        exp_cnt   = '0;
        @(negedge clk);
        do_reset();

        // ADD, zero wait
        model_instr(0, 0, 0, 0, 0);
        cur_op = 7'h33;
        run_trace(-1);
        check("add_count", 32'(instret_count), 32'd1);
        // LW, 3 memory wait cycles
        model_instr(2, 0, 0, 3, 0);
        run_trace(-1);
        // SW, zero wait
        model_instr(3, 0, 0, 0, 0);
        run_trace(-1);
        // ADDI with 2 execute and 1 writeback stall
        model_instr(0, 0, 2, 0, 1);
        cur_op = 7'h13;
        run_trace(-1);
        check("stall_count", 32'(instret_count), 32'd4);

        repeat (70) begin
            cls = $urandom_range(0, 3);
            fw  = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
            mw  = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
            model_instr(cls, fw, $urandom_range(0, 2), mw,
                        $urandom_range(0, 2));
            run_trace(-1);
        end
        check("no_illegal", 32'(illegal), 32'd0);
        check("no_timeout", 32'(timeout), 32'd0);

        // async reset in the middle of a load's memory access
        model_instr(2, 1, 0, 5, 0);
        run_trace(6);
        q.delete();
        check("mid_dmem", 32'(dmem_req), 32'd1);
        do_reset();

        // fetch timeout after 16 request cycles
        for (int i = 0; i < 16; i++)
            push(3'd0, 7'b1000000, 0, -1);
        for (int i = 0; i < 3; i++)
            push(3'd7, 7'b0000000, -1, -1);
        run_trace(-1);
        check("fetch_timeout", 32'(timeout), 32'd1);
        check("fetch_to_ill", 32'(illegal), 32'd0);
        @(negedge clk);
        do_reset();

        // acknowledge on the last allowed cycle
        model_instr(1, 15, 0, 0, 0);
        run_trace(-1);
        check("late_ack_to", 32'(timeout), 32'd0);

        // memory timeout on a store
        model_instr(3, 0, 0, 16, 0);
        q.pop_back();
        for (int i = 0; i < 2; i++)
            push(3'd7, 7'b0000000, -1, -1);
        run_trace(-1);
        check("mem_timeout", 32'(timeout), 32'd1);
        do_reset();

        // illegal opcodes: 0x7F then random ones
        for (int k = 0; k < 4; k++) begin
            bad = 7'h7F;
            if (k > 0)
                do bad = 7'($urandom); while (model_legal(bad));
            cur_op = bad;
            push(3'd0, 7'b1001000, 1, -1);
            push(3'd1, 7'b0000000, -1, -1);
            for (int i = 0; i < 3; i++)
                push(3'd7, 7'b0000000, -1, -1);
            run_trace(-1);
            check("illegal_set", 32'(illegal), 32'd1);
            check("illegal_to", 32'(timeout), 32'd0);
            do_reset();
        end

        model_instr(0, 0, 0, 0, 0);
        run_trace(-1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
